// File: rtl/random_led_picker.sv
// Random LED index generator: free-running 16-bit Fibonacci LFSR feeding a
// rejection sampler that yields an in-range index different from the previous one.
module random_led_picker #(
    parameter int          LED_NUM   = 18,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_TRIES = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       next_req,
    input  logic                       seed_load,
    input  logic [15:0]                seed_in,
    output logic [$clog2(LED_NUM)-1:0] random_value,
    output logic                       valid,
    output logic                       busy
);

    localparam int IDX_W = $clog2(LED_NUM);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    localparam logic [IDX_W:0]   LED_NUM_W = (IDX_W + 1)'(LED_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LED_NUM - 1);
    localparam logic [TRY_W-1:0] LAST_TRY  = TRY_W'(MAX_TRIES - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SEARCH = 1'b1
    } state_t;

    logic [15:0]      r_lfsr;
    logic             w_fb;
    logic [15:0]      w_seed;

    logic [IDX_W-1:0] r_cand_p1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TRY_W-1:0] r_tries;
    logic [TRY_W-1:0] w_tries_nxt;
    logic [IDX_W-1:0] r_value;
    logic [IDX_W-1:0] w_value_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_primed;
    logic             w_primed_nxt;

    logic             w_accept;
    logic [IDX_W-1:0] w_wrap;

    // Stage p0: LFSR, advancing every clock; a seed load overrides the shift.
    assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_seed = (seed_in == 16'h0000) ? SEED : seed_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= SEED;
        end else if (seed_load) begin
            r_lfsr <= w_seed;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    // Stage p1: candidate captured from the LFSR, evaluated one clock later.
    always_ff @(posedge clk) begin
        r_cand_p1 <= r_lfsr[IDX_W-1:0];
    end

    assign w_accept = ({1'b0, r_cand_p1} < LED_NUM_W) && (r_cand_p1 != r_value);
    assign w_wrap   = (r_value == LAST_IDX) ? '0 : r_value + 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_tries_nxt  = r_tries;
        w_value_nxt  = r_value;
        w_valid_nxt  = r_valid;
        w_busy_nxt   = r_busy;
        w_primed_nxt = r_primed;
        case (r_state)
            S_IDLE: begin
                if (next_req) begin
                    w_valid_nxt  = 1'b0;
                    w_busy_nxt   = 1'b1;
                    w_tries_nxt  = '0;
                    w_primed_nxt = 1'b0;
                    w_state_nxt  = S_SEARCH;
                end
            end
            S_SEARCH: begin
                // First search clock only fills the candidate register.
                if (!r_primed) begin
                    w_primed_nxt = 1'b1;
                end else if (w_accept) begin
                    w_value_nxt = r_cand_p1;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (r_tries == LAST_TRY) begin
                    w_value_nxt = w_wrap;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tries_nxt = r_tries + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Stage p2: control and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_tries  <= '0;
            r_value  <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_primed <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tries  <= w_tries_nxt;
            r_value  <= w_value_nxt;
            r_valid  <= w_valid_nxt;
            r_busy   <= w_busy_nxt;
            r_primed <= w_primed_nxt;
        end
    end

    assign random_value = r_value;
    assign valid        = r_valid;
    assign busy         = r_busy;

endmodule
